// File: rtl/raster_prim_fetch_ctrl.sv
// raster_prim_fetch_ctrl
// Walks one tile's primitive index buffer: reads each 32-bit index, turns it
// into a primitive record address and hands it (tagged with the tile
// rectangle) to the setup stage.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising edge where both valid and ready are high; the valid side holds
// valid and its payload stable until that transfer, and valid never depends
// combinationally on ready.
module raster_prim_fetch_ctrl #(
  parameter int DCR_DATA_BITS  = 32,
  parameter int TILE_DATA_BITS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DCR_DATA_BITS-1:0]  pidx_addr,
  input  logic [DCR_DATA_BITS-1:0]  pidx_size,
  input  logic [DCR_DATA_BITS-1:0]  pbuf_addr,
  input  logic [DCR_DATA_BITS-1:0]  pbuf_stride,
  input  logic [TILE_DATA_BITS-1:0] tile_left,
  input  logic [TILE_DATA_BITS-1:0] tile_top,
  input  logic [TILE_DATA_BITS-1:0] tile_width,
  input  logic [TILE_DATA_BITS-1:0] tile_height,
  output logic                      mem_req_valid,
  output logic [DCR_DATA_BITS-1:0]  mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DCR_DATA_BITS-1:0]  mem_rsp_data,
  output logic                      mem_rsp_ready,
  output logic                      prim_valid,
  input  logic                      prim_ready,
  output logic [DCR_DATA_BITS-1:0]  prim_addr,
  output logic [TILE_DATA_BITS-1:0] prim_left,
  output logic [TILE_DATA_BITS-1:0] prim_top,
  output logic [TILE_DATA_BITS-1:0] prim_width,
  output logic [TILE_DATA_BITS-1:0] prim_height,
  output logic                      prim_last,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RSP  = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DCR_DATA_BITS-1:0] ONE = DCR_DATA_BITS'(1);

  state_t                    state;
  logic [DCR_DATA_BITS-1:0]  cnt;
  logic [DCR_DATA_BITS-1:0]  pidx_addr_q;
  logic [DCR_DATA_BITS-1:0]  pidx_size_q;
  logic [DCR_DATA_BITS-1:0]  pbuf_addr_q;
  logic [DCR_DATA_BITS-1:0]  pbuf_stride_q;
  logic [TILE_DATA_BITS-1:0] tile_left_q;
  logic [TILE_DATA_BITS-1:0] tile_top_q;
  logic [TILE_DATA_BITS-1:0] tile_width_q;
  logic [TILE_DATA_BITS-1:0] tile_height_q;
  logic [DCR_DATA_BITS-1:0]  prim_addr_q;
  logic                      prim_last_q;

  // Sequencer: latch config on start, then one request / one response / one
  // emit per index until the last index has been handed downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pidx_addr_q   <= '0;
      pidx_size_q   <= '0;
      pbuf_addr_q   <= '0;
      pbuf_stride_q <= '0;
      tile_left_q   <= '0;
      tile_top_q    <= '0;
      tile_width_q  <= '0;
      tile_height_q <= '0;
      prim_addr_q   <= '0;
      prim_last_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pidx_addr_q   <= pidx_addr;
            pidx_size_q   <= pidx_size;
            pbuf_addr_q   <= pbuf_addr;
            pbuf_stride_q <= pbuf_stride;
            tile_left_q   <= tile_left;
            tile_top_q    <= tile_top;
            tile_width_q  <= tile_width;
            tile_height_q <= tile_height;
            cnt           <= '0;
            state         <= (pidx_size == '0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_RSP;
        end
        S_RSP: begin
          if (mem_rsp_valid) begin
            // Low DCR_DATA_BITS only: the address wraps rather than saturates.
            prim_addr_q <= pbuf_addr_q + mem_rsp_data * pbuf_stride_q;
            // size is at least 1 here, so size-1 cannot underflow.
            prim_last_q <= (cnt == pidx_size_q - ONE);
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (prim_ready) begin
            cnt   <= cnt + ONE;
            state <= prim_last_q ? S_DONE : S_REQ;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; no input-to-output paths.
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = (state == S_REQ) ? (pidx_addr_q + (cnt << 2)) : '0;
  assign mem_rsp_ready = (state == S_RSP);
  assign prim_valid    = (state == S_EMIT);
  assign prim_addr     = prim_addr_q;
  assign prim_last     = prim_last_q && (state == S_EMIT);
  assign prim_left     = tile_left_q;
  assign prim_top      = tile_top_q;
  assign prim_width    = tile_width_q;
  assign prim_height   = tile_height_q;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_raster_prim_fetch_ctrl.sv
// Directed bench for raster_prim_fetch_ctrl: basic walk, backpressure, empty
// tile, address wrap, start while busy, reset mid-tile, tile tagging.
module tb_raster_prim_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pidx_addr, pidx_size, pbuf_addr, pbuf_stride;
  logic [15:0] tile_left, tile_top, tile_width, tile_height;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_ready;
  logic        prim_valid;
  logic        prim_ready;
  logic [31:0] prim_addr;
  logic [15:0] prim_left, prim_top, prim_width, prim_height;
  logic        prim_last;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int t0;

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_req_valid) req_cnt++;
  end

  raster_prim_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .pidx_addr(pidx_addr), .pidx_size(pidx_size),
    .pbuf_addr(pbuf_addr), .pbuf_stride(pbuf_stride),
    .tile_left(tile_left), .tile_top(tile_top),
    .tile_width(tile_width), .tile_height(tile_height),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_ready(mem_rsp_ready),
    .prim_valid(prim_valid), .prim_ready(prim_ready),
    .prim_addr(prim_addr),
    .prim_left(prim_left), .prim_top(prim_top),
    .prim_width(prim_width), .prim_height(prim_height),
    .prim_last(prim_last), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] pa, input logic [31:0] ps,
                         input logic [31:0] ba, input logic [31:0] bs);
    pidx_addr = pa; pidx_size = ps; pbuf_addr = ba; pbuf_stride = bs;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Driver: serve one primitive, entered while the DUT should be in REQ.
  task automatic serve(input logic [31:0] exp_req, input logic [31:0] idx,
                       input logic [31:0] exp_prim, input logic exp_last,
                       input int req_stall, input int prim_stall);
    chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("req_addr", mem_req_addr, exp_req);
    for (int i = 0; i < req_stall; i++) begin
      step();
      chk("req_valid_hold", {31'd0, mem_req_valid}, 32'd1);
      chk("req_addr_hold", mem_req_addr, exp_req);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("rsp_ready", {31'd0, mem_rsp_ready}, 32'd1);
    chk("req_valid_in_rsp", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = idx;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'hDEAD_BEEF;
    chk("prim_valid", {31'd0, prim_valid}, 32'd1);
    chk("prim_addr", prim_addr, exp_prim);
    chk("prim_last", {31'd0, prim_last}, {31'd0, exp_last});
    chk("rsp_ready_in_emit", {31'd0, mem_rsp_ready}, 32'd0);
    chk("prim_tile", {prim_left[7:0], prim_top[7:0], prim_width[7:0], prim_height[7:0]},
        32'h10_20_08_08);
    for (int i = 0; i < prim_stall; i++) begin
      step();
      chk("prim_valid_hold", {31'd0, prim_valid}, 32'd1);
      chk("prim_addr_hold", prim_addr, exp_prim);
      chk("prim_last_hold", {31'd0, prim_last}, {31'd0, exp_last});
    end
    prim_ready = 1'b1;
    step();
    prim_ready = 1'b0;
  endtask

  task automatic set_tile();
    tile_left = 16'd16; tile_top = 16'd32; tile_width = 16'd8; tile_height = 16'd8;
  endtask

  task automatic scramble_tile();
    tile_left = 16'h7777; tile_top = 16'h5555; tile_width = 16'h3333; tile_height = 16'h1111;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    set_cfg(32'h0, 32'h0, 32'h0, 32'h0);
    set_tile();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; prim_ready = 1'b0;
    step(); step();
    // Reset state
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_prim_addr", prim_addr, 32'd0);
    chk("rst_prim_last", {31'd0, prim_last}, 32'd0);
    chk("rst_prim_tile", {prim_left, prim_top}, 32'd0);
    reset = 1'b0;
    step();

    // Basic walk with tile tagging; tile inputs change after start
    set_cfg(32'h1000, 32'd3, 32'h8000, 32'h40);
    set_tile();
    pulse_start();
    scramble_tile();
    set_cfg(32'h9999, 32'd7, 32'h1111, 32'h3);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    t0 = cyc;
    serve(32'h1000, 32'd5, 32'h8140, 1'b0, 0, 0);
    serve(32'h1004, 32'd0, 32'h8000, 1'b0, 0, 0);
    serve(32'h1008, 32'd2, 32'h8080, 1'b1, 0, 0);
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_latency", cyc - t0, 32'd9);
    step();
    chk("basic_done_once", done_cnt, 32'd1);
    chk("basic_idle", {31'd0, busy}, 32'd0);

    // Backpressure: same tile, every handshake stalled
    set_cfg(32'h1000, 32'd3, 32'h8000, 32'h40);
    set_tile();
    pulse_start();
    scramble_tile();
    serve(32'h1000, 32'd5, 32'h8140, 1'b0, 4, 3);
    serve(32'h1004, 32'd0, 32'h8000, 1'b0, 4, 3);
    serve(32'h1008, 32'd2, 32'h8080, 1'b1, 4, 3);
    chk("bp_done", {31'd0, done}, 32'd1);
    step();
    chk("bp_done_count", done_cnt, 32'd2);

    // Empty tile: no memory traffic
    req_cnt = 0;
    set_cfg(32'h2000, 32'd0, 32'h0, 32'h4);
    pulse_start();
    chk("empty_busy", {31'd0, busy}, 32'd1);
    chk("empty_done", {31'd0, done}, 32'd1);
    step();
    chk("empty_idle", {31'd0, busy}, 32'd0);
    chk("empty_done_low", {31'd0, done}, 32'd0);
    chk("empty_no_req", req_cnt, 32'd0);

    // Address wrap
    set_cfg(32'h2000, 32'd1, 32'hFFFF_FFF0, 32'h20);
    set_tile();
    pulse_start();
    serve(32'h2000, 32'd1, 32'h0000_0010, 1'b1, 0, 0);
    chk("wrap_done", {31'd0, done}, 32'd1);
    step();

    // Start while busy is ignored; the next start uses the new config
    set_cfg(32'h3000, 32'd2, 32'h100, 32'h8);
    set_tile();
    pulse_start();
    serve(32'h3000, 32'd1, 32'h108, 1'b0, 0, 0);
    set_cfg(32'h4000, 32'd1, 32'h200, 32'h4);
    pulse_start();
    chk("sb_still_req", {29'd0, dbg_state}, 32'd1);
    serve(32'h3004, 32'd3, 32'h118, 1'b1, 0, 0);
    chk("sb_done", {31'd0, done}, 32'd1);
    step();
    chk("sb_idle", {31'd0, busy}, 32'd0);
    pulse_start();
    serve(32'h4000, 32'd2, 32'h208, 1'b1, 0, 0);
    step();

    // Reset in RSP with a response pending
    done_cnt = 0;
    set_cfg(32'h5000, 32'd2, 32'h0, 32'h10);
    pulse_start();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("mid_in_rsp", {29'd0, dbg_state}, 32'd2);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'd9; reset = 1'b1;
    step();
    reset = 1'b0; mem_rsp_valid = 1'b0;
    chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
    chk("mid_rst_prim_valid", {31'd0, prim_valid}, 32'd0);
    chk("mid_rst_prim_addr", prim_addr, 32'd0);
    chk("mid_rst_tile", {prim_width, prim_height}, 32'd0);
    step();
    chk("mid_rst_no_done", done_cnt, 32'd0);
    set_tile();
    pulse_start();
    serve(32'h5000, 32'd1, 32'h10, 1'b0, 0, 0);
    serve(32'h5004, 32'd2, 32'h20, 1'b1, 0, 0);
    chk("mid_rerun_done", {31'd0, done}, 32'd1);
    step();

    // Maximum size: first primitive is not the last
    set_cfg(32'h6000, 32'hFFFF_FFFF, 32'h0, 32'h4);
    pulse_start();
    serve(32'h6000, 32'd3, 32'hC, 1'b0, 0, 0);
    chk("max_next_req", mem_req_addr, 32'h6004);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("max_rst_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
